pipeline_stage_reg: RTL and testbench
=====================================

# pipeline_stage_reg

Parametrised elastic pipeline register placed between any two CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB) in place of the fixed per-stage latch. It carries an opaque packed payload of WIDTH bits through a DEPTH-entry in-order queue with a valid/ready handshake. It also provides synchronous flush, sticky halt tracking and an optional same-cycle ready pass-through mode.

## Interface

Parameters:
- WIDTH, 128, payload width in bits (≥1)
- DEPTH, 2, storage entries (1..4)
- PASS_READY, 0, when 1 a full stage accepts input in the same cycle it is drained

Ports:
- CLK  input  1  clock, rising edge
- nRST  input  1  asynchronous active-low reset
- in_valid  input  1  upstream offers payload
- in_ready  output  1  stage accepts payload this cycle
- in_data  input  WIDTH  payload
- in_halt  input  1  payload is a halt instruction
- flush  input  1  synchronous squash of all held entries
- out_valid  output  1  head entry present
- out_ready  input  1  downstream consumes head this cycle
- out_data  output  WIDTH  head payload; all zeros when empty
- out_halt  output  1  head entry is a halt
- halted  output  1  sticky: a halt entry has been consumed downstream
- count  output  $clog2(DEPTH+1)  occupied entries

## Operation

- Storage: circular array of DEPTH entries of {halt, data}, with write pointer, read pointer and count. Pointers wrap modulo DEPTH.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = !halt_seen & !halted & (count < DEPTH | (PASS_READY & out_ready & count == DEPTH)).
- out_valid = (count != 0). out_data and out_halt come from the head entry. When empty, out_data = 0 and out_halt = 0, which is a bubble.
- Count update:
  - push only: count + 1
  - pop only: count - 1
  - push and pop together: count unchanged
  - count never exceeds DEPTH and never underflows.
- halt_seen (internal): set on push with in_halt = 1. While set, no further push is accepted, so no wrong-path work is accepted past a halt.
- halted: set on pop of an entry whose halt bit is 1. It is cleared only by reset.
- Flush has priority over push and pop in the same cycle:
  - count, pointers and halt_seen go to 0.
  - A concurrent push is discarded.
  - A concurrent pop is still visible to downstream that cycle, but its halt bit does not set halted.
  - halted is not affected by flush.
- Reset mid-operation: all state, including the payload array, returns to reset values asynchronously.
- in_data is sampled only on push. Payload contents are never interpreted.

## Timing

- Reset values:
  - in_ready = 1
  - out_valid = 0
  - out_data = 0
  - out_halt = 0
  - halted = 0
  - count = 0
- Latency: a payload pushed in cycle N is on out_data with out_valid = 1 in cycle N+1.
- Throughput:
  - One transfer per cycle in steady state when DEPTH ≥ 2, or when PASS_READY = 1.
  - DEPTH = 1 with PASS_READY = 0 gives one transfer every two cycles under continuous flow.
- in_ready depends combinationally on out_ready only when PASS_READY = 1. Otherwise it is a function of registered state only.
- out_valid, out_data, out_halt and count are registered-state functions, with no combinational path from inputs.
- Upstream must hold in_data and in_valid stable until in_ready. Downstream may deassert out_ready at any time without data loss.
- halted rises in the cycle after the halt entry pops.

## Structure

- Payload structs (e.g. the packed ID/EX control + operand bundle) belong in control_unit_types_pkg. Stage instances use WIDTH = $bits(<struct>) and cast at the boundary. word_t and regbits_t stay in cpu_types_pkg.
- No sub-module: the storage array, pointers and count are inline in one module of roughly 150–250 lines.

## Test plan

- Reset then fill: push 0xA5, then 0x3C, with out_ready = 0 and DEPTH = 2.
  - Expect count = 2 and in_ready = 0.
  - Expect out_data = 0xA5 until a pop, then 0x3C.
- Continuous flow: 8 back-to-back pushes of values 1..8 with out_ready = 1 and DEPTH = 2.
  - Expect outputs 1..8 in order, one per cycle, starting 1 cycle after the first push.
  - Repeat with DEPTH = 1, PASS_READY = 1: same result while count stays ≤ 1.
- Wrap-around: 10 random push/pop cycles with DEPTH = 3 and a random out_ready pattern.
  - Expect the scoreboard to match order.
  - Expect count always equal to pushes minus pops, in range 0..3.
- Flush while full, with a simultaneous push of 0x77:
  - Next cycle: count = 0, out_valid = 0, out_data = 0.
  - 0x77 never appears at the output.
- Halt handling:
  - Push 0x11 with in_halt = 1, then offer 0x22. Expect in_ready = 0 and 0x22 not accepted.
  - Pop the halt entry. Expect halted = 1 next cycle.
  - Pulse flush. Expect halted to remain 1.
- Async reset: drop nRST mid-cycle while count = 2.
  - Expect all outputs at reset values immediately, before the next CLK edge.

Source files
------------

// File: rtl/pipeline_stage_reg_pkg.sv
// Shared types and helpers for the elastic pipeline stage register.
package pipeline_stage_reg_pkg;

    // Queue operation for one cycle, encoded as {push, pop}.
    typedef enum logic [1:0] {
        Q_IDLE = 2'b00,
        Q_POP  = 2'b01,
        Q_PUSH = 2'b10,
        Q_BOTH = 2'b11
    } q_op_e;

    function automatic q_op_e q_op(input logic push, input logic pop);
        return q_op_e'({push, pop});
    endfunction

    // Pointer width for a DEPTH-entry ring; a single entry still needs one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipeline_stage_reg_if.sv
// Valid/ready payload channel with a halt marker travelling alongside the data.
interface pipeline_stage_reg_if #(
    parameter int unsigned WIDTH = 128
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             halt;

    // Producer side of the channel.
    modport master (
        output valid,
        output data,
        output halt,
        input  ready
    );

    // Consumer side of the channel.
    modport slave (
        input  valid,
        input  data,
        input  halt,
        output ready
    );
endinterface

// File: rtl/pipeline_stage_reg.sv
// Elastic pipeline register: DEPTH-entry in-order ring of {halt, data} with
// valid/ready handshake, synchronous flush, sticky halted flag and optional
// same-cycle ready pass-through when full.
module pipeline_stage_reg
    import pipeline_stage_reg_pkg::*;
#(
    parameter int unsigned  WIDTH      = 128,
    parameter int unsigned  DEPTH      = 2,
    parameter bit           PASS_READY = 1'b0,
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    pipeline_stage_reg_if.slave  in_if,
    pipeline_stage_reg_if.master out_if,
    input  logic                 flush,
    output logic                 halted,
    output logic [CNT_W-1:0]     count
);

    localparam int unsigned      PTR_W    = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] halt_q;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             halt_seen_q, halt_seen_d;
    logic             halted_q, halted_d;

    logic             in_ready;
    logic             out_valid;
    logic             head_halt;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Handshake qualifiers. Once a halt has been accepted nothing further is
    // taken, so no wrong-path work lands behind it.
    always_comb begin
        out_valid = (count_q != '0);
        head_halt = halt_q[rd_ptr_q];
        in_ready  = !halt_seen_q && !halted_q &&
                    ((count_q < FULL_CNT) ||
                     (PASS_READY && out_if.ready && (count_q == FULL_CNT)));
        push      = in_if.valid && in_ready;
        pop       = out_valid && out_if.ready;
    end

    // Next-state for pointers, occupancy and halt tracking; flush wins over
    // push and pop, but a flushed pop of a halt must not raise halted.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        halt_seen_d = halt_seen_q;
        halted_d    = halted_q | (pop & head_halt & !flush);

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            halt_seen_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_next(wr_ptr_q);
                if (in_if.halt) begin
                    halt_seen_d = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end
            case (q_op(push, pop))
                Q_PUSH:  count_d = count_q + 1'b1;
                Q_POP:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            halt_seen_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            halt_seen_q <= halt_seen_d;
            halted_q    <= halted_d;
        end
    end

    // Payload storage; the array is cleared on reset as well so no stale
    // payload survives a reset. With PASS_READY the slot written while full is
    // the head being popped in the same cycle, which is safe at the edge.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            halt_q <= '0;
        end else if (push && !flush) begin
            data_q[wr_ptr_q] <= in_if.data;
            halt_q[wr_ptr_q] <= in_if.halt;
        end
    end

    // Outputs; an empty stage presents an all-zero bubble.
    always_comb begin
        in_if.ready  = in_ready;
        out_if.valid = out_valid;
        out_if.data  = out_valid ? data_q[rd_ptr_q] : '0;
        out_if.halt  = out_valid & head_halt;
        halted       = halted_q;
        count        = count_q;
    end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Directed bench for pipeline_stage_reg: a DEPTH=2 stage driven from a vector
// table, a DEPTH=1 pass-through stage and a DEPTH=3 stage against a queue model.
module tb_pipeline_stage_reg;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    pipeline_stage_reg_if #(.WIDTH(8)) up2 ();
    pipeline_stage_reg_if #(.WIDTH(8)) dn2 ();
    pipeline_stage_reg_if #(.WIDTH(8)) up1 ();
    pipeline_stage_reg_if #(.WIDTH(8)) dn1 ();
    pipeline_stage_reg_if #(.WIDTH(8)) up3 ();
    pipeline_stage_reg_if #(.WIDTH(8)) dn3 ();

    logic       fl2, fl1, fl3;
    logic       hd2, hd1, hd3;
    logic [1:0] cnt2;
    logic [0:0] cnt1;
    logic [1:0] cnt3;

    pipeline_stage_reg #(.WIDTH(8), .DEPTH(2), .PASS_READY(1'b0)) u_d2 (
        .CLK(CLK), .nRST(nRST), .in_if(up2), .out_if(dn2),
        .flush(fl2), .halted(hd2), .count(cnt2)
    );
    pipeline_stage_reg #(.WIDTH(8), .DEPTH(1), .PASS_READY(1'b1)) u_d1 (
        .CLK(CLK), .nRST(nRST), .in_if(up1), .out_if(dn1),
        .flush(fl1), .halted(hd1), .count(cnt1)
    );
    pipeline_stage_reg #(.WIDTH(8), .DEPTH(3), .PASS_READY(1'b0)) u_d3 (
        .CLK(CLK), .nRST(nRST), .in_if(up3), .out_if(dn3),
        .flush(fl3), .halted(hd3), .count(cnt3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       h;
        logic       f;
        logic       r;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_oh;
        logic       e_hd;
        int         e_cnt;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input int sel, input logic v, input logic [7:0] d,
                         input logic h, input logic f, input logic r);
        case (sel)
            2: begin up2.valid = v; up2.data = d; up2.halt = h; fl2 = f; dn2.ready = r; end
            1: begin up1.valid = v; up1.data = d; up1.halt = h; fl1 = f; dn1.ready = r; end
            default: begin up3.valid = v; up3.data = d; up3.halt = h; fl3 = f; dn3.ready = r; end
        endcase
    endtask

    task automatic sample(input int sel, output logic ir, output logic ov, output logic [7:0] od,
                          output logic oh, output logic hd, output int cnt);
        case (sel)
            2: begin ir = up2.ready; ov = dn2.valid; od = dn2.data; oh = dn2.halt; hd = hd2; cnt = int'(cnt2); end
            1: begin ir = up1.ready; ov = dn1.valid; od = dn1.data; oh = dn1.halt; hd = hd1; cnt = int'(cnt1); end
            default: begin ir = up3.ready; ov = dn3.valid; od = dn3.data; oh = dn3.halt; hd = hd3; cnt = int'(cnt3); end
        endcase
    endtask

    task automatic check_reset_values(input int sel, input string tag);
        logic ir, ov, oh, hd;
        logic [7:0] od;
        int cnt;
        sample(sel, ir, ov, od, oh, hd, cnt);
        check({tag, ".in_ready"},  int'(ir), 1);
        check({tag, ".out_valid"}, int'(ov), 0);
        check({tag, ".out_data"},  int'(od), 0);
        check({tag, ".out_halt"},  int'(oh), 0);
        check({tag, ".halted"},    int'(hd), 0);
        check({tag, ".count"},     cnt,      0);
    endtask

    task automatic flow_test(input int sel, input string tag);
        logic ir, ov, oh, hd;
        logic [7:0] od;
        int cnt;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) drive(sel, 1'b1, 8'(c + 1), 1'b0, 1'b0, 1'b1);
            else       drive(sel, 1'b0, 8'h00,     1'b0, 1'b0, 1'b1);
            #1;
            sample(sel, ir, ov, od, oh, hd, cnt);
            if (c < 8) check({tag, ".in_ready"}, int'(ir), 1);
            if (c >= 1 && c <= 8) begin
                check({tag, ".out_valid"}, int'(ov), 1);
                check({tag, ".out_data"},  int'(od), c);
            end else begin
                check({tag, ".out_valid_idle"}, int'(ov), 0);
            end
            check({tag, ".count_le1"}, int'(cnt <= 1), 1);
            tick();
        end
        drive(sel, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic ir, ov, oh, hd;
        logic [7:0] od;
        int cnt;
        logic [7:0] mq[$];

        tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1};
        tbl[3]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0,  1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 2};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0,  1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 2};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1,  1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 2};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1};
        tbl[7]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1};
        tbl[8]  = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b1,  1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 2};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0};
        tbl[10] = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 1};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0};
        tbl[13] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0};
        tbl[14] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0,  1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1};
        tbl[15] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1,  1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1};
        tbl[16] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0};
        tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0};
        tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0};

        nRST = 1'b0;
        drive(2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        tick();

        check_reset_values(1, "d1_reset");
        check_reset_values(3, "d3_reset");

        // Fill, drain, flush and halt handling on the DEPTH=2 stage.
        for (int i = 0; i < 19; i++) begin
            drive(2, tbl[i].v, tbl[i].d, tbl[i].h, tbl[i].f, tbl[i].r);
            #1;
            sample(2, ir, ov, od, oh, hd, cnt);
            check($sformatf("vec%0d.in_ready", i),  int'(ir), int'(tbl[i].e_ir));
            check($sformatf("vec%0d.out_valid", i), int'(ov), int'(tbl[i].e_ov));
            check($sformatf("vec%0d.out_data", i),  int'(od), int'(tbl[i].e_od));
            check($sformatf("vec%0d.out_halt", i),  int'(oh), int'(tbl[i].e_oh));
            check($sformatf("vec%0d.halted", i),    int'(hd), int'(tbl[i].e_hd));
            check($sformatf("vec%0d.count", i),     cnt,      tbl[i].e_cnt);
            tick();
        end
        drive(2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Async reset mid-cycle clears sticky halted immediately.
        #3;
        nRST = 1'b0;
        #1;
        check_reset_values(2, "areset_halted");
        @(negedge CLK);
        nRST = 1'b1;
        tick();

        // Fill to two entries, then async reset mid-cycle.
        drive(2, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        tick();
        drive(2, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        tick();
        drive(2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        sample(2, ir, ov, od, oh, hd, cnt);
        check("areset_pre.count", cnt, 2);
        #2;
        nRST = 1'b0;
        #1;
        check_reset_values(2, "areset_full");
        @(negedge CLK);
        nRST = 1'b1;
        tick();

        // Flush in the same cycle a halt entry pops: halted must stay low.
        drive(2, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
        tick();
        drive(2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        #1;
        sample(2, ir, ov, od, oh, hd, cnt);
        check("flushpop.out_halt", int'(oh), 1);
        tick();
        drive(2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        sample(2, ir, ov, od, oh, hd, cnt);
        check("flushpop.halted",   int'(hd), 0);
        check("flushpop.count",    cnt,      0);
        check("flushpop.in_ready", int'(ir), 1);

        // Back-to-back flow through DEPTH=2 and DEPTH=1 pass-through stages.
        flow_test(2, "flow_d2");
        flow_test(1, "flow_d1p");

        // DEPTH=1 pass-through: a push accepted while full is discarded by flush.
        drive(1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1, 1'b1, 8'h77, 1'b0, 1'b1, 1'b1);
        #1;
        sample(1, ir, ov, od, oh, hd, cnt);
        check("d1flush.in_ready", int'(ir), 1);
        check("d1flush.out_data", int'(od), 8'hAA);
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            #1;
            sample(1, ir, ov, od, oh, hd, cnt);
            check("d1flush.out_valid", int'(ov), 0);
            check("d1flush.out_data",  int'(od), 0);
            check("d1flush.count",     cnt,      0);
            tick();
        end

        // DEPTH=3 with random offers and a random out_ready pattern.
        for (int c = 0; c < 40; c++) begin
            logic       v, r, e_ir, do_push, do_pop;
            logic [7:0] d;
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));
            if (c >= 34) begin
                v = 1'b0;
                r = 1'b1;
            end
            drive(3, v, d, 1'b0, 1'b0, r);
            #1;
            sample(3, ir, ov, od, oh, hd, cnt);
            e_ir = (mq.size() < 3);
            check("wrap.in_ready",  int'(ir), int'(e_ir));
            check("wrap.out_valid", int'(ov), int'(mq.size() != 0));
            check("wrap.out_data",  int'(od), (mq.size() != 0) ? int'(mq[0]) : 0);
            check("wrap.count",     cnt,      mq.size());
            do_push = v && e_ir;
            do_pop  = (mq.size() != 0) && r;
            tick();
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(d);
        end
        drive(3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        sample(3, ir, ov, od, oh, hd, cnt);
        check("wrap.drained", cnt, mq.size());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
